// File: rtl/fetch2_cti_scan.sv
`default_nettype none
// ============================================================================
// Module   : fetch2_cti_scan
// Purpose  : Second fetch stage: finds the first taken CTI in a bundle, raises
//            decode-time redirects, allocates CTI-queue tags, registers bundle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch2_cti_scan #(
    parameter int FETCH_WIDTH      = 4,
    parameter int SIZE_PC          = 32,
    parameter int SIZE_INSTRUCTION = 64,
    parameter int INST_BYTES       = 8,
    parameter int CTIQ_DEPTH       = 16,
    parameter int RETIRE_WIDTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush_i,
    input  logic                                   stall_i,
    input  logic                                   recoverFlag_i,
    input  logic [$clog2(CTIQ_DEPTH)-1:0]          recoverTag_i,
    input  logic [RETIRE_WIDTH-1:0]                commitCti_i,
    input  logic                                   fs1Ready_i,
    input  logic [SIZE_PC-1:0]                     pc_i,
    input  logic [FETCH_WIDTH*SIZE_INSTRUCTION-1:0] instBundle_i,
    input  logic [FETCH_WIDTH-1:0]                 isCtrl_i,
    input  logic [2*FETCH_WIDTH-1:0]               ctrlType_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]         decTarget_i,
    input  logic [FETCH_WIDTH-1:0]                 btbHit_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]         btbTarget_i,
    input  logic [FETCH_WIDTH-1:0]                 prediction_i,
    input  logic [SIZE_PC-1:0]                     addrRAS_i,
    output logic                                   flagRecoverID_o,
    output logic [SIZE_PC-1:0]                     targetAddrID_o,
    output logic                                   flagRtrID_o,
    output logic                                   flagCallID_o,
    output logic [SIZE_PC-1:0]                     callPCID_o,
    output logic [FETCH_WIDTH-1:0]                 instValid_o,
    output logic [FETCH_WIDTH*(SIZE_INSTRUCTION+2*SIZE_PC+$clog2(CTIQ_DEPTH)+1)-1:0] instPacket_o,
    output logic [$clog2(CTIQ_DEPTH):0]            ctiqCount_o,
    output logic                                   ctiQueueFull_o,
    output logic                                   fs2Ready_o
);

    localparam int c_TAG_W = $clog2(CTIQ_DEPTH);
    localparam int c_CNT_W = c_TAG_W + 1;
    localparam int c_IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int c_PKT_W = SIZE_INSTRUCTION + 2*SIZE_PC + c_TAG_W + 1;

    localparam logic [1:0] c_TYPE_RET  = 2'b00;
    localparam logic [1:0] c_TYPE_CALL = 2'b01;
    localparam logic [1:0] c_TYPE_COND = 2'b11;

    logic [SIZE_PC-1:0]          w_slotPc  [FETCH_WIDTH];
    logic [SIZE_PC-1:0]          w_decTgt  [FETCH_WIDTH];
    logic [SIZE_PC-1:0]          w_btbTgt  [FETCH_WIDTH];
    logic [SIZE_PC-1:0]          w_tgtF    [FETCH_WIDTH];
    logic [1:0]                  w_type    [FETCH_WIDTH];
    logic [c_TAG_W-1:0]          w_tag     [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]      w_taken;
    logic [FETCH_WIDTH-1:0]      w_filter;
    logic [FETCH_WIDTH-1:0]      w_alloc;
    logic                        w_anyTaken;
    logic [c_IDX_W-1:0]          w_firstIdx;
    logic                        w_redirect;
    logic                        w_accept;
    logic [c_TAG_W-1:0]          w_tailAlloc;
    logic [c_CNT_W-1:0]          w_allocCnt;
    logic [c_CNT_W-1:0]          w_commitCnt;
    logic [c_TAG_W-1:0]          w_headNext;
    logic [c_TAG_W-1:0]          w_recoverDist;
    logic [c_CNT_W-1:0]          w_countNext;
    logic [FETCH_WIDTH*c_PKT_W-1:0] w_packet;

    logic [c_TAG_W-1:0]          r_head;
    logic [c_TAG_W-1:0]          r_tail;
    logic [c_CNT_W-1:0]          r_count;
    logic [FETCH_WIDTH-1:0]      r_instValid;
    logic [FETCH_WIDTH*c_PKT_W-1:0] r_packet;

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            assign w_slotPc[gi] = pc_i + SIZE_PC'(gi * INST_BYTES);
            assign w_decTgt[gi] = decTarget_i[gi*SIZE_PC +: SIZE_PC];
            assign w_btbTgt[gi] = btbTarget_i[gi*SIZE_PC +: SIZE_PC];
            assign w_type[gi]   = ctrlType_i[2*gi +: 2];
            assign w_taken[gi]  = isCtrl_i[gi] & (prediction_i[gi] | (w_type[gi] != c_TYPE_COND));
            assign w_tgtF[gi]   = (isCtrl_i[gi] && w_type[gi] == c_TYPE_RET) ? addrRAS_i : w_decTgt[gi];
            assign w_packet[gi*c_PKT_W +: c_PKT_W] = {instBundle_i[gi*SIZE_INSTRUCTION +: SIZE_INSTRUCTION],
                                                      w_slotPc[gi], w_tgtF[gi], w_tag[gi], prediction_i[gi]};
        end
    endgenerate

    // Slots after the first taken CTI are dropped; everything up to and including it survives.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        w_anyTaken = 1'b0;
        w_firstIdx = '0;
        w_filter   = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_filter[i] = ~seen;
            if (w_taken[i] && !seen) begin
                w_anyTaken = 1'b1;
                w_firstIdx = c_IDX_W'(i);
            end
            seen = seen | w_taken[i];
        end
    end

    // Tags follow program order from the tail; non-allocating slots carry tag 0.
    always_comb begin
        w_tailAlloc = r_tail;
        w_allocCnt  = '0;
        w_alloc     = w_filter & isCtrl_i;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_tag[i] = '0;
            if (w_alloc[i]) begin
                w_tag[i]    = w_tailAlloc;
                w_tailAlloc = w_tailAlloc + c_TAG_W'(1);
                w_allocCnt  = w_allocCnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_commitCnt = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            w_commitCnt = w_commitCnt + c_CNT_W'(commitCti_i[i]);
        end
    end

    assign ctiQueueFull_o = (r_count > c_CNT_W'(CTIQ_DEPTH - FETCH_WIDTH));
    assign fs2Ready_o     = fs1Ready_i & ~ctiQueueFull_o;
    assign w_accept       = fs1Ready_i & ~stall_i & ~ctiQueueFull_o & ~flush_i & ~recoverFlag_i;

    // A BTB hit on a return is trusted; other types must also agree with predecode.
    assign w_redirect = w_anyTaken & (~btbHit_i[w_firstIdx] |
                        ((w_type[w_firstIdx] != c_TYPE_RET) && (w_btbTgt[w_firstIdx] != w_decTgt[w_firstIdx])));

    assign flagRecoverID_o = w_redirect & w_accept;
    assign flagRtrID_o     = flagRecoverID_o & (w_type[w_firstIdx] == c_TYPE_RET);
    assign flagCallID_o    = flagRecoverID_o & (w_type[w_firstIdx] == c_TYPE_CALL);
    assign targetAddrID_o  = !w_anyTaken ? '0 :
                             (w_type[w_firstIdx] == c_TYPE_RET) ? addrRAS_i : w_decTgt[w_firstIdx];
    assign callPCID_o      = w_anyTaken ? w_slotPc[w_firstIdx] : '0;

    assign w_headNext    = r_head + w_commitCnt[c_TAG_W-1:0];
    assign w_recoverDist = recoverTag_i - w_headNext;

    always_comb begin
        w_countNext = r_count - w_commitCnt;
        if (recoverFlag_i) begin
            w_countNext = {1'b0, w_recoverDist} + c_CNT_W'(1);
        end else if (w_accept) begin
            w_countNext = r_count + w_allocCnt - w_commitCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_instValid <= '0;
            r_packet    <= '0;
        end else begin
            r_head  <= w_headNext;
            r_count <= w_countNext;
            if (recoverFlag_i) begin
                r_tail      <= recoverTag_i + c_TAG_W'(1);
                r_instValid <= '0;
            end else if (flush_i) begin
                r_instValid <= '0;
            end else if (stall_i) begin
                r_instValid <= r_instValid;
            end else if (w_accept) begin
                r_tail      <= w_tailAlloc;
                r_instValid <= w_filter;
                r_packet    <= w_packet;
            end else begin
                r_instValid <= '0;
            end
        end
    end

    a_commitLegal: assert property (@(posedge clk) disable iff (reset) w_commitCnt <= r_count);

    assign instValid_o  = r_instValid;
    assign instPacket_o = r_packet;
    assign ctiqCount_o  = r_count;

endmodule
`default_nettype wire
